// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode constants and the receiver state encoding.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } uart_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with load, half-bit/full-bit ticks and a raw wrap strobe.
// TICK_OFFSET delays both ticks by that many counts so a decision can follow a sampling window.
module uart_bit_timer #(
    parameter int CLK_DIV     = 5000,
    parameter int TICK_OFFSET = 0,
    localparam int CW         = $clog2(CLK_DIV)
) (
    input  logic          clk,
    input  logic          res,
    input  logic          clr,
    input  logic [CW-1:0] clr_val,
    output logic          half_tick,
    output logic          full_tick,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_AT  = CW'((CLK_DIV / 2 - 1 + TICK_OFFSET) % CLK_DIV);
    localparam logic [CW-1:0] FULL_AT  = CW'((CLK_DIV - 1 + TICK_OFFSET) % CLK_DIV);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (res) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= clr_val;
        end else if (cnt_reg == LAST_CNT) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign half_tick = (cnt_reg == HALF_AT);
    assign full_tick = (cnt_reg == FULL_AT);
    assign wrap      = (cnt_reg == LAST_CNT);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with line qualification, false-start rejection and error flags.
// Define RX_MAJORITY_EN to take each bit as the 2-of-3 majority around its centre count.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV     = 5000,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int IDLE_BITS   = 12
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

`ifdef RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = 4;
    localparam int IW = $clog2(IDLE_BITS + 1);

    uart_state_t state_reg, state_next;

    logic                 rx_meta_reg, rx_s_reg, rx_s_d_reg;
    logic                 fall_edge, bit_sample;
    logic                 half_tick, full_tick, wrap;
    logic                 timer_clr;
    logic [CW-1:0]        timer_clr_val;
    logic                 idle_clr, idle_inc, frame_start;
    logic                 shift_en, par_en, stop_en, bit_cnt_clr, done;
    logic [IW-1:0]        idle_cnt_reg;
    logic [BW-1:0]        bit_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rx_parity_bad_reg, rx_stop_bad_reg;
    logic [DATA_BITS-1:0] data_out_reg;
    logic                 data_valid_reg, parity_err_reg, frame_err_reg, overrun_reg;
    logic                 load_word;

    always_ff @(posedge clk) begin
        if (res) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_s_d_reg  <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
            rx_s_d_reg  <= rx_s_reg;
        end
    end

    assign fall_edge = rx_s_d_reg & ~rx_s_reg;

`ifdef RX_MAJORITY_EN
    // hist_reg holds rx_s from one and two cycles back; decision is taken at centre+1.
    logic [1:0] hist_reg;

    always_ff @(posedge clk) begin
        if (res) begin
            hist_reg <= 2'b11;
        end else begin
            hist_reg <= {hist_reg[0], rx_s_reg};
        end
    end

    assign bit_sample = (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & rx_s_reg) |
                        (hist_reg[0] & rx_s_reg);
`else
    assign bit_sample = rx_s_reg;
`endif

    uart_bit_timer #(
        .CLK_DIV     (CLK_DIV),
        .TICK_OFFSET (MAJ)
    ) u_timer (
        .clk       (clk),
        .res       (res),
        .clr       (timer_clr),
        .clr_val   (timer_clr_val),
        .half_tick (half_tick),
        .full_tick (full_tick),
        .wrap      (wrap)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            state_reg <= ST_SYNC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        timer_clr     = 1'b0;
        timer_clr_val = '0;
        idle_clr      = 1'b0;
        idle_inc      = 1'b0;
        frame_start   = 1'b0;
        shift_en      = 1'b0;
        par_en        = 1'b0;
        stop_en       = 1'b0;
        bit_cnt_clr   = 1'b0;
        done          = 1'b0;
        case (state_reg)
            ST_SYNC: begin
                if (!rx_s_reg) begin
                    idle_clr  = 1'b1;
                    timer_clr = 1'b1;
                end else if (wrap) begin
                    if (idle_cnt_reg == IW'(IDLE_BITS - 1)) begin
                        idle_clr   = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        idle_inc = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (fall_edge) begin
                    timer_clr   = 1'b1;
                    frame_start = 1'b1;
                    state_next  = ST_START;
                end
            end
            ST_START: begin
                if (half_tick) begin
                    if (bit_sample) begin
                        state_next = ST_IDLE;
                    end else begin
                        // Majority decision lands one count late; preload keeps centres aligned.
                        timer_clr     = 1'b1;
                        timer_clr_val = CW'(MAJ);
                        state_next    = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (full_tick) begin
                    shift_en = 1'b1;
                    if (bit_cnt_reg == BW'(DATA_BITS - 1)) begin
                        bit_cnt_clr = 1'b1;
                        state_next  = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (full_tick) begin
                    par_en     = 1'b1;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (full_tick) begin
                    stop_en = 1'b1;
                    if (bit_cnt_reg == BW'(STOP_BITS - 1)) begin
                        bit_cnt_clr = 1'b1;
                        state_next  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (rx_stop_bad_reg) begin
                    timer_clr  = 1'b1;
                    state_next = ST_SYNC;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            idle_cnt_reg      <= '0;
            bit_cnt_reg       <= '0;
            shift_reg         <= '0;
            rx_parity_bad_reg <= 1'b0;
            rx_stop_bad_reg   <= 1'b0;
        end else begin
            if (idle_clr || state_reg != ST_SYNC) begin
                idle_cnt_reg <= '0;
            end else if (idle_inc) begin
                idle_cnt_reg <= idle_cnt_reg + IW'(1);
            end
            if (bit_cnt_clr || frame_start) begin
                bit_cnt_reg <= '0;
            end else if (shift_en || stop_en) begin
                bit_cnt_reg <= bit_cnt_reg + BW'(1);
            end
            if (frame_start) begin
                rx_parity_bad_reg <= 1'b0;
                rx_stop_bad_reg   <= 1'b0;
            end
            if (shift_en) begin
                shift_reg <= {bit_sample, shift_reg[DATA_BITS-1:1]};
            end
            if (par_en) begin
                rx_parity_bad_reg <= ((^shift_reg) ^ bit_sample) != (PARITY_MODE == PARITY_ODD);
            end
            if (stop_en && !bit_sample) begin
                rx_stop_bad_reg <= 1'b1;
            end
        end
    end

    // A finished word is only taken if the output slot is empty or being emptied now.
    assign load_word = done & (~data_valid_reg | data_ready);

    always_ff @(posedge clk) begin
        if (res) begin
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            overrun_reg <= done & data_valid_reg & ~data_ready;
            if (load_word) begin
                data_out_reg   <= shift_reg;
                parity_err_reg <= rx_parity_bad_reg;
                frame_err_reg  <= rx_stop_bad_reg;
                data_valid_reg <= 1'b1;
            end else if (data_valid_reg && data_ready) begin
                data_valid_reg <= 1'b0;
            end
        end
    end

    assign data_out    = data_out_reg;
    assign data_valid  = data_valid_reg;
    assign parity_err  = parity_err_reg;
    assign frame_err   = frame_err_reg;
    assign overrun_err = overrun_reg;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 receiver (A) and a 7-bit even-parity, 2-stop receiver (B).
// Honours RX_MAJORITY_EN (extra latency cycle and a centre-glitch scenario).
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int C    = 16;
    localparam int IDLE = 12;
`ifdef RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    typedef struct packed {
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       ready_a = 1'b1, ready_b = 1'b1;
    logic [7:0] dout_a;
    logic [6:0] dout_b;
    logic       dv_a, dv_b, pe_a, pe_b, fe_a, fe_b, ov_a, ov_b;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];
    int   ov_cnt_a = 0, ov_cnt_b = 0, exp_ov_a = 0;
    logic ov_prev_a = 1'b0, ov_prev_b = 1'b0, dv_prev_a = 1'b0;
    int   rise_cyc_a = -1, start_cyc_a = 0;
    logic done_a = 1'b0, done_b = 1'b0;

    uart_rx_param #(
        .CLK_DIV(C), .DATA_BITS(8), .PARITY_MODE(PARITY_NONE), .STOP_BITS(1), .IDLE_BITS(IDLE)
    ) dut_a (
        .clk(clk), .res(res), .rx(rx_a), .data_out(dout_a), .data_valid(dv_a),
        .data_ready(ready_a), .parity_err(pe_a), .frame_err(fe_a), .overrun_err(ov_a)
    );

    uart_rx_param #(
        .CLK_DIV(C), .DATA_BITS(7), .PARITY_MODE(PARITY_EVEN), .STOP_BITS(2), .IDLE_BITS(IDLE)
    ) dut_b (
        .clk(clk), .res(res), .rx(rx_b), .data_out(dout_b), .data_valid(dv_b),
        .data_ready(ready_b), .parity_err(pe_b), .frame_err(fe_b), .overrun_err(ov_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic take_word(input string nm, input exp_t e, input logic [8:0] data,
                             input logic pe, input logic fe);
        $display("%s word %03h pe %0b fe %0b", nm, data, pe, fe);
        check_eq({nm, "_data"}, 32'(data), 32'(e.data));
        check_eq({nm, "_parity_err"}, 32'(pe), 32'(e.pe));
        check_eq({nm, "_frame_err"}, 32'(fe), 32'(e.fe));
    endtask

    // Output monitor: scores every accepted word and every overrun pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (!res && dv_a && ready_a) begin
                if (exp_a.size() == 0) check_eq("a_spurious_valid", 32'(dv_a), 32'd0);
                else take_word("a", exp_a.pop_front(), {1'b0, dout_a}, pe_a, fe_a);
            end
            if (!res && dv_b && ready_b) begin
                if (exp_b.size() == 0) check_eq("b_spurious_valid", 32'(dv_b), 32'd0);
                else take_word("b", exp_b.pop_front(), {2'b00, dout_b}, pe_b, fe_b);
            end
            if (ov_a) begin
                ov_cnt_a++;
                check_eq("a_overrun_width", 32'(ov_prev_a), 32'd0);
            end
            if (ov_b) begin
                ov_cnt_b++;
                check_eq("b_overrun_width", 32'(ov_prev_b), 32'd0);
            end
            if (dv_a && !dv_prev_a) rise_cyc_a = cyc;
            ov_prev_a = ov_a;
            ov_prev_b = ov_b;
            dv_prev_a = dv_a;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic set_rx(input int which, input logic b);
        if (which == 0) rx_a = b;
        else rx_b = b;
    endtask

    task automatic idle_bits(input int k);
        repeat (k * C) @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input int which, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.pe   = pe;
        e.fe   = fe;
        if (which == 0) exp_a.push_back(e);
        else exp_b.push_back(e);
    endtask

    // Drive one frame; called at posedge+1. glitch_bit >= 0 inverts that bit for one centre cycle.
    task automatic send(input int which, input logic [8:0] data, input int nbits, input int pmode,
                        input logic par_flip, input int nstop, input logic stop0_bad,
                        input int glitch_bit);
        logic [15:0] bits;
        int          n;
        int          ones;
        bits = '0;
        n = 1;
        ones = $countones(data);
        for (int i = 0; i < nbits; i++) begin
            bits[n] = data[i];
            n++;
        end
        if (pmode != 0) begin
            bits[n] = ((pmode == 2) ? ones[0] : ~ones[0]) ^ par_flip;
            n++;
        end
        for (int s = 0; s < nstop; s++) begin
            bits[n] = !(stop0_bad && s == 0);
            n++;
        end
        if (which == 0) start_cyc_a = cyc;
        for (int k = 0; k < n; k++) begin
            set_rx(which, bits[k]);
            if (k == glitch_bit) begin
                repeat (C / 2) @(posedge clk);
                #1 set_rx(which, ~bits[k]);
                @(posedge clk);
                #1 set_rx(which, bits[k]);
                repeat (C / 2 - 1) @(posedge clk);
                #1;
            end else begin
                repeat (C) @(posedge clk);
                #1;
            end
        end
        set_rx(which, 1'b1);
    endtask

    initial begin
        int unsigned d;
        int unsigned gap;
        logic        flip;
        int          ov0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("rst_a_valid", 32'(dv_a), 32'd0);
        check_eq("rst_a_data", 32'(dout_a), 32'd0);
        check_eq("rst_a_flags", {29'd0, pe_a, fe_a, ov_a}, 32'd0);
        check_eq("rst_b_valid", 32'(dv_b), 32'd0);
        check_eq("rst_b_data", 32'(dout_b), 32'd0);
        check_eq("rst_b_flags", {29'd0, pe_b, fe_b, ov_b}, 32'd0);
        @(posedge clk);
        #1 res = 1'b0;
        idle_bits(IDLE + 1);

        // 8N1 word held until accepted, with exact output latency
        ready_a = 1'b0;
        expect_word(0, 9'h0A5, 1'b0, 1'b0);
        send(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b0, -1);
        check_eq("t1_latency", 32'(rise_cyc_a - start_cyc_a), 32'(9 * C + C / 2 + 4 + MAJ));
        repeat (2 * C) @(posedge clk);
        @(negedge clk);
        check_eq("t1_valid_held", 32'(dv_a), 32'd1);
        check_eq("t1_data_held", 32'(dout_a), 32'h0A5);
        @(posedge clk);
        #1 ready_a = 1'b1;
        @(posedge clk);
        #1 ready_a = 1'b0;
        @(negedge clk);
        check_eq("t1_valid_drop", 32'(dv_a), 32'd0);
        @(posedge clk);
        #1 ready_a = 1'b1;

        // 7E2 with the parity bit inverted
        expect_word(1, 9'h055, 1'b1, 1'b0);
        send(1, 9'h055, 7, 2, 1'b1, 2, 1'b0, -1);
        idle_bits(1);

        // stop bit low: flagged, then the line must requalify
        expect_word(0, 9'h03C, 1'b0, 1'b1);
        send(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1, -1);
        idle_bits(1);
        send(0, 9'h099, 8, 0, 1'b0, 1, 1'b0, -1);
        idle_bits(IDLE + 1);
        expect_word(0, 9'h042, 1'b0, 1'b0);
        send(0, 9'h042, 8, 0, 1'b0, 1, 1'b0, -1);
        idle_bits(1);

        // short low glitch is a false start
        set_rx(0, 1'b0);
        repeat (6) @(posedge clk);
        #1 set_rx(0, 1'b1);
        idle_bits(2);
        @(negedge clk);
        check_eq("t4_no_valid", 32'(dv_a), 32'd0);
        @(posedge clk);
        #1;
        expect_word(0, 9'h081, 1'b0, 1'b0);
        send(0, 9'h081, 8, 0, 1'b0, 1, 1'b0, -1);
        idle_bits(1);

        // back-to-back frames while blocked: second word dropped, one overrun pulse
        ready_a = 1'b0;
        ov0 = ov_cnt_a;
        expect_word(0, 9'h011, 1'b0, 1'b0);
        send(0, 9'h011, 8, 0, 1'b0, 1, 1'b0, -1);
        send(0, 9'h022, 8, 0, 1'b0, 1, 1'b0, -1);
        exp_ov_a++;
        idle_bits(1);
        check_eq("t5_overrun_count", 32'(ov_cnt_a - ov0), 32'd1);
        @(negedge clk);
        check_eq("t5_kept_data", 32'(dout_a), 32'h011);
        check_eq("t5_kept_valid", 32'(dv_a), 32'd1);
        @(posedge clk);
        #1 ready_a = 1'b1;
        idle_bits(1);

        // reset in the middle of a frame with a word still pending
        ready_a = 1'b0;
        send(0, 9'h05A, 8, 0, 1'b0, 1, 1'b0, -1);
        fork
            send(0, 9'h077, 8, 0, 1'b0, 1, 1'b0, -1);
            begin
                repeat (4 * C) @(posedge clk);
                #1 res = 1'b1;
                @(posedge clk);
                #1 res = 1'b0;
                @(negedge clk);
                check_eq("t6_valid", 32'(dv_a), 32'd0);
                check_eq("t6_data", 32'(dout_a), 32'd0);
                check_eq("t6_flags", {29'd0, pe_a, fe_a, ov_a}, 32'd0);
            end
        join
        ready_a = 1'b1;
        idle_bits(IDLE + 1);
        expect_word(0, 9'h03E, 1'b0, 1'b0);
        send(0, 9'h03E, 8, 0, 1'b0, 1, 1'b0, -1);
        idle_bits(1);

`ifdef RX_MAJORITY_EN
        // single-cycle glitch exactly at a data-bit centre
        expect_word(0, 9'h096, 1'b0, 1'b0);
        send(0, 9'h096, 8, 0, 1'b0, 1, 1'b0, 4);
        idle_bits(1);
`endif

        // randomized traffic on both receivers with a randomly stalling consumer
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    d = $urandom_range(0, 255);
                    gap = $urandom_range(0, 2);
                    expect_word(0, 9'(d), 1'b0, 1'b0);
                    send(0, 9'(d), 8, 0, 1'b0, 1, 1'b0, -1);
                    if (gap != 0) idle_bits(int'(gap));
                end
                done_a = 1'b1;
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    d = $urandom_range(0, 127);
                    flip = 1'($urandom_range(0, 1));
                    expect_word(1, 9'(d), flip, 1'b0);
                    send(1, 9'(d), 7, 2, flip, 2, 1'b0, -1);
                    if ((i % 3) == 0) idle_bits(1);
                end
                done_b = 1'b1;
            end
            begin
                while (!(done_a && done_b)) begin
                    @(posedge clk);
                    #1;
                    ready_a = ($urandom_range(0, 3) != 0);
                    ready_b = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ready_a = 1'b1;
        ready_b = 1'b1;
        idle_bits(2);

        check_eq("a_words_left", 32'(exp_a.size()), 32'd0);
        check_eq("b_words_left", 32'(exp_b.size()), 32'd0);
        check_eq("a_overrun_total", 32'(ov_cnt_a), 32'(exp_ov_a));
        check_eq("b_overrun_total", 32'(ov_cnt_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
